ext_mem_arbiter: RTL and testbench



---
 rtl/ext_mem_arbiter_pkg.sv | 19 +
 rtl/ext_mem_arbiter_rr_arb2.sv | 34 +++
 rtl/ext_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ext_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_arbiter_pkg.sv
// rtl/ext_mem_arbiter_pkg.sv - shared types and constants for the external memory arbiter
//
// Package ext_mem_pkg: access-sequencer state encoding and pin output-enable levels.

package ext_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    WR,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic [7:0] OE_DRIVE   = 8'hFF;
  localparam logic [7:0] OE_RELEASE = 8'h00;

endpackage

// File: rtl/ext_mem_arbiter_rr_arb2.sv
// rtl/ext_mem_arbiter_rr_arb2.sv - two-input round-robin picker
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     request vector
//   advance      commit the current pick (updates last_grant)
//   grant_idx    index of the winner
//   grant_valid  at least one request is pending

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_idx,
  output logic       grant_valid
);

  // Resets to 1 so requester 0 wins the first tie.
  logic last_grant;

  assign grant_valid = |req;
  // On a tie the requester that did not win last time goes next.
  assign grant_idx   = (req == 2'b11) ? ~last_grant : req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - shares the 8-bit external memory pins between two requesters
//
// Each 16-bit access is serialised as address-low, address-high, then a write
// strobe or a read wait/capture. Outputs are registered from the phase state,
// so each pin phase appears on the pins one cycle after the state is entered.
// Optional macro EXT_MEM_HI_SKIP_EN: skip the address-high phase when the
// high byte matches the last one driven.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[1:0], req_we[1:0]      per-requester request and op (1 = write)
//   req_addr0/1, req_wdata0/1  per-requester address and write data
//   ack[1:0]                   one-cycle one-hot completion pulse
//   rdata                      captured read data, held until next capture
//   busy                       an access is in flight
//   pin_out, pin_oe, pin_in    external bus value, output enable, read data
//   ale_lo, ale_hi, mem_we     address-low, address-high and write strobes

module ext_mem_arbiter
  import ext_mem_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [7:0]        req_wdata0,
  input  logic [7:0]        req_wdata1,
  output logic [1:0]        ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [7:0]        pin_out,
  output logic [7:0]        pin_oe,
  input  logic [7:0]        pin_in,
  output logic              ale_lo,
  output logic              ale_hi,
  output logic              mem_we
);

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              grant_q;
  logic [3:0]        cnt;

  logic grant_idx;
  logic grant_valid;
  logic advance;
  logic hi_hit;

  assign advance = (state == IDLE);

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .advance     (advance),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef EXT_MEM_HI_SKIP_EN
  logic [7:0] hi_cache;
  logic       hi_valid;

  assign hi_hit = hi_valid && (addr_q[15:8] == hi_cache);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cache <= 8'h00;
      hi_valid <= 1'b0;
    end else if (state == ADDR_HI) begin
      hi_cache <= addr_q[15:8];
      hi_valid <= 1'b1;
    end
  end
`else
  assign hi_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      grant_q <= 1'b0;
      cnt     <= 4'd0;
      ack     <= 2'b00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      pin_out <= 8'h00;
      pin_oe  <= OE_RELEASE;
      ale_lo  <= 1'b0;
      ale_hi  <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      // Pins released and strobes low unless the current phase drives them.
      ack     <= 2'b00;
      pin_out <= 8'h00;
      pin_oe  <= OE_RELEASE;
      ale_lo  <= 1'b0;
      ale_hi  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            addr_q  <= grant_idx ? req_addr1 : req_addr0;
            wdata_q <= grant_idx ? req_wdata1 : req_wdata0;
            we_q    <= req_we[grant_idx];
            grant_q <= grant_idx;
            busy    <= 1'b1;
            state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          pin_oe  <= OE_DRIVE;
          pin_out <= addr_q[7:0];
          ale_lo  <= 1'b1;
          cnt     <= RD_LOAD;
          if (!hi_hit)   state <= ADDR_HI;
          else if (we_q) state <= WR;
          else           state <= ext_mem_pkg::RD_WAIT;
        end
        ADDR_HI: begin
          pin_oe  <= OE_DRIVE;
          pin_out <= addr_q[15:8];
          ale_hi  <= 1'b1;
          cnt     <= RD_LOAD;
          state   <= we_q ? WR : ext_mem_pkg::RD_WAIT;
        end
        WR: begin
          pin_oe  <= OE_DRIVE;
          pin_out <= wdata_q;
          mem_we  <= 1'b1;
          state   <= DONE;
        end
        ext_mem_pkg::RD_WAIT: begin
          if (cnt == 4'd0) begin
            rdata <= pin_in;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ack[grant_q] <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - scoreboard bench for ext_mem_arbiter

module tb_ext_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr0, req_addr1;
  logic [7:0]  req_wdata0, req_wdata1;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  pin_out, pin_oe, pin_in;
  logic        ale_lo, ale_hi, mem_we;

  ext_mem_arbiter #(.RD_WAIT(2), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .ack        (ack),
    .rdata      (rdata),
    .busy       (busy),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .pin_in     (pin_in),
    .ale_lo     (ale_lo),
    .ale_hi     (ale_hi),
    .mem_we     (mem_we)
  );

  typedef struct {
    logic [1:0] ack;
    bit         we;
    logic [7:0] rd;
    int         t0;
    int         lat;  // 0 = latency not checked
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [1:0] ack_prev = 2'b00;

`ifdef EXT_MEM_HI_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every ack pops the oldest expected access.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((ale_lo | ale_hi | mem_we) != 1'b0)
        check("strobe_excl", 32'($countones({ale_lo, ale_hi, mem_we})), 32'd1);
      if (ack != 2'b00) begin
        check("ack_onehot", 32'($onehot(ack)), 32'd1);
        check("ack_1cyc", {30'd0, ack_prev}, 32'd0);
        if (sb.size() == 0) begin
          check("ack_unexpected", {30'd0, ack}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_idx", {30'd0, ack}, {30'd0, e.ack});
          if (!e.we) check("rdata", {24'd0, rdata}, {24'd0, e.rd});
          if (e.lat != 0) check("latency", cyc - e.t0, e.lat);
        end
      end
      ack_prev <= ack;
    end else begin
      ack_prev <= 2'b00;
    end
  end

  task automatic push_exp(input int idx, input bit we, input logic [7:0] rd, input int lat);
    exp_t e;
    e.ack = (idx == 0) ? 2'b01 : 2'b10;
    e.we  = we;
    e.rd  = rd;
    e.t0  = cyc;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int idx, input bit we, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] pin);
    @(posedge clk);
    #1;
    if (idx == 0) begin
      req_addr0 = a; req_wdata0 = wd;
    end else begin
      req_addr1 = a; req_wdata1 = wd;
    end
    req_we[idx] = we;
    pin_in      = pin;
    req[idx]    = 1'b1;
  endtask

  task automatic wait_ack(input int idx, output int hi_cnt);
    bit seen;
    seen   = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ale_hi) hi_cnt++;
      if (ack[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    req[idx] = 1'b0;
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int hc;
    int k;
    rst_n = 1'b0;
    req = 2'b00; req_we = 2'b00;
    req_addr0 = 16'h0; req_addr1 = 16'h0;
    req_wdata0 = 8'h0; req_wdata1 = 8'h0;
    pin_in = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pin_out", {24'd0, pin_out}, 32'd0);
    check("rst_pin_oe", {24'd0, pin_oe}, 32'd0);
    check("rst_strobes", {29'd0, ale_lo, ale_hi, mem_we}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single write, req 0: phase sequence then ack at edge 5
    drive_req(0, 1'b1, 16'h12A5, 8'h3C, 8'h00);
    push_exp(0, 1'b1, 8'h00, 5);
    repeat (3) @(negedge clk);
    check("wr_ale_lo", {15'd0, ale_lo, pin_oe, pin_out}, {15'd0, 1'b1, 8'hFF, 8'hA5});
    check("wr_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wr_ale_hi", {15'd0, ale_hi, pin_oe, pin_out}, {15'd0, 1'b1, 8'hFF, 8'h12});
    @(negedge clk);
    check("wr_mem_we", {15'd0, mem_we, pin_oe, pin_out}, {15'd0, 1'b1, 8'hFF, 8'h3C});
    wait_ack(0, hc);

    // Single read, req 1: pins released while waiting, ack at edge 6
    drive_req(1, 1'b0, 16'h0040, 8'h00, 8'h7E);
    push_exp(1, 1'b0, 8'h7E, 6);
    repeat (5) @(negedge clk);
    check("rd_oe_wait1", {24'd0, pin_oe}, 32'd0);
    @(negedge clk);
    check("rd_oe_wait2", {24'd0, pin_oe}, 32'd0);
    wait_ack(1, hc);

    // Both requesters held: strict alternation 0,1,0,1
    @(posedge clk);
    #1;
    req_addr0 = 16'h0101; req_wdata0 = 8'h99; req_we[0] = 1'b1;
    req_addr1 = 16'h0202; req_we[1] = 1'b0; pin_in = 8'h5A;
    req = 2'b11;
    for (int i = 0; i < 4; i++) push_exp(i % 2, (i % 2) == 0, 8'h5A, 0);
    k = 0;
    for (int i = 0; i < 100 && k < 4; i++) begin
      @(negedge clk);
      if (ack != 2'b00) k++;
    end
    req = 2'b00;
    check("dual_ack_count", k, 4);

    // Reset in the RD_WAIT cycle aborts; request is then re-served
    drive_req(1, 1'b0, 16'h0040, 8'h00, 8'hC3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ack", {30'd0, ack}, 32'd0);
    check("abort_pins", {pin_oe, pin_out}, 32'd0);
    check("abort_strobes", {29'd0, ale_lo, ale_hi, mem_we}, 32'd0);
    check("abort_busy_rdata", {23'd0, busy, rdata}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(1, 1'b0, 8'hC3, 6);
    wait_ack(1, hc);

    // High-byte reuse: 0x1200 then 0x1201
    drive_req(0, 1'b0, 16'h1200, 8'h00, 8'h11);
    push_exp(0, 1'b0, 8'h11, 6);
    wait_ack(0, hc);
    check("hi_first", hc, 1);
    drive_req(0, 1'b0, 16'h1201, 8'h00, 8'h22);
    push_exp(0, 1'b0, 8'h22, SKIP ? 5 : 6);
    wait_ack(0, hc);
    check("hi_second", hc, SKIP ? 0 : 1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("end_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
